// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
package mod_updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Prescaler width; a DIV of 1 still gets a 1-bit width so declarations stay legal.
  function automatic int pw_of(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mod_updown_counter_div.sv
// Enable prescaler: step fires once per DIV enabled cycles; clr restarts the count.
module clk_en_divider
  import mod_updown_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = pw_of(DIV);

  if (DIV == 1) begin : g_nodiv
    // No prescaler register: every enabled cycle is a step.
    logic unused_div;
    assign unused_div = ^{clk, rst, clr};
    assign step       = en;
  end else begin : g_div
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);
    logic [PW-1:0] pre;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      pre <= '0;
      else if (clr) pre <= '0;
      else if (en)  pre <= (pre == TERM) ? '0 : pre + 1'b1;
    end

    assign step = en && (pre == TERM);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Runtime-modulus up/down counter with load, prescaler and wrap/saturate end handling.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int                N    = 10,
  parameter longint unsigned   MOD  = 64'd1 << N,
  parameter int                DIV  = 1,
  parameter int                MODE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap,
  output logic         step
);

  if (N < 1 || N > 32 || MOD > (64'd1 << N) || MOD < 2 || DIV < 1) begin : g_bad_params
    $error("mod_updown_counter: illegal N/MOD/DIV combination");
  end

  // End value held at N bits; for MOD == 2**N this is all-ones and wrap is the natural rollover.
  localparam logic [N-1:0] TOP = N'(MOD - 1);

  logic [N-1:0] q_nxt;
  logic         wrap_nxt;

  clk_en_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .step (step)
  );

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = (d > TOP) ? TOP : d;
    end else if (step) begin
      if (up) begin
        if (q == TOP) begin
          wrap_nxt = 1'b1;
          if (MODE == MODE_WRAP) q_nxt = '0;
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          wrap_nxt = 1'b1;
          if (MODE == MODE_WRAP) q_nxt = TOP;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign max_tick = (q == TOP);
  assign min_tick = (q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four configurations run in lock-step against an arithmetic model.
module tb_mod_updown_counter;

  localparam int NI = 4;
  // Instance configs: A = 10-bit full range, B = mod-10 wrap, C = mod-10 saturate, D = mod-10 div-3.
  localparam int CMOD [NI] = '{1024, 10, 10, 10};
  localparam int CDIV [NI] = '{1, 1, 1, 3};
  localparam int CSAT [NI] = '{0, 0, 1, 0};

  logic test_clk = 1'b0;
  logic rst;
  logic en [NI];
  logic up [NI];
  logic load [NI];
  int   dval [NI];

  logic [9:0] d0, q0;
  logic [3:0] d1, d2, d3, q1, q2, q3;
  logic mx [NI];
  logic mn [NI];
  logic wr [NI];
  logic st [NI];

  assign d0 = 10'(dval[0]);
  assign d1 = 4'(dval[1]);
  assign d2 = 4'(dval[2]);
  assign d3 = 4'(dval[3]);

  always #5 test_clk = ~test_clk;

  mod_updown_counter #(.N(10), .MOD(1024), .DIV(1), .MODE(0)) u_a (
    .clk(test_clk), .rst(rst), .en(en[0]), .up(up[0]), .load(load[0]), .d(d0),
    .q(q0), .max_tick(mx[0]), .min_tick(mn[0]), .wrap(wr[0]), .step(st[0]));
  mod_updown_counter #(.N(4), .MOD(10), .DIV(1), .MODE(0)) u_b (
    .clk(test_clk), .rst(rst), .en(en[1]), .up(up[1]), .load(load[1]), .d(d1),
    .q(q1), .max_tick(mx[1]), .min_tick(mn[1]), .wrap(wr[1]), .step(st[1]));
  mod_updown_counter #(.N(4), .MOD(10), .DIV(1), .MODE(1)) u_c (
    .clk(test_clk), .rst(rst), .en(en[2]), .up(up[2]), .load(load[2]), .d(d2),
    .q(q2), .max_tick(mx[2]), .min_tick(mn[2]), .wrap(wr[2]), .step(st[2]));
  mod_updown_counter #(.N(4), .MOD(10), .DIV(3), .MODE(0)) u_d (
    .clk(test_clk), .rst(rst), .en(en[3]), .up(up[3]), .load(load[3]), .d(d3),
    .q(q3), .max_tick(mx[3]), .min_tick(mn[3]), .wrap(wr[3]), .step(st[3]));

  int vectors = 0;
  int miscompares = 0;
  int mq [NI];
  int mpre [NI];
  bit mw [NI];
  int wcnt [NI];
  int scnt [NI];

  function automatic logic [31:0] get_q(input int i);
    case (i)
      0:       return 32'(q0);
      1:       return 32'(q1);
      2:       return 32'(q2);
      default: return 32'(q3);
    endcase
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: got %0d want %0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i] = 0; mpre[i] = 0; mw[i] = 1'b0;
    end
  endtask

  // Counter rules in plain integer arithmetic: one step per DIV enabled cycles, leaving 0..MOD-1 is an end event.
  function automatic void model_edge(input int i);
    int t;
    mw[i] = 1'b0;
    if (load[i]) begin
      mq[i]   = (dval[i] > CMOD[i] - 1) ? CMOD[i] - 1 : dval[i];
      mpre[i] = 0;
    end else if (en[i]) begin
      if (mpre[i] < CDIV[i] - 1) begin
        mpre[i]++;
      end else begin
        mpre[i] = 0;
        t = mq[i] + (up[i] ? 1 : -1);
        if (t < 0 || t >= CMOD[i]) begin
          mw[i] = 1'b1;
          if (CSAT[i] == 0) mq[i] = (t + CMOD[i]) % CMOD[i];
        end else begin
          mq[i] = t;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_q"},   i, get_q(i),      32'(mq[i]));
      chk({tag, "_wrap"}, i, 32'(wr[i]),    32'(mw[i]));
      chk({tag, "_max"}, i, 32'(mx[i]),     32'(mq[i] == CMOD[i] - 1));
      chk({tag, "_min"}, i, 32'(mn[i]),     32'(mq[i] == 0));
    end
  endtask

  // Entered one time unit after a rising edge; leaves one time unit after the next.
  task automatic cyc();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("step", i, 32'(st[i]), 32'(en[i] && mpre[i] == CDIV[i] - 1));
      if (st[i]) scnt[i]++;
    end
    @(posedge test_clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
    check_outputs("cyc");
    for (int i = 0; i < NI; i++) if (wr[i]) wcnt[i]++;
  endtask

  task automatic run(input int i, input logic e, input logic u, input int n);
    en[i] = e;
    up[i] = u;
    repeat (n) cyc();
    en[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      en[i] = 1'b0; up[i] = 1'b1; load[i] = 1'b0; dval[i] = 0;
      wcnt[i] = 0; scnt[i] = 0;
    end
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge test_clk);
    #1;
    rst = 1'b0;

    // Full-range free-running count.
    run(0, 1'b1, 1'b1, 1500);
    chk("t1_q",     0, get_q(0),    32'd476);
    chk("t1_wraps", 0, 32'(wcnt[0]), 32'd1);

    // Mod-10 wrap both directions.
    run(1, 1'b1, 1'b1, 25);
    chk("t2_up_q",     1, get_q(1),    32'd5);
    chk("t2_up_wraps", 1, 32'(wcnt[1]), 32'd2);
    wcnt[1] = 0;
    run(1, 1'b1, 1'b0, 7);
    chk("t2_dn_q",     1, get_q(1),    32'd8);
    chk("t2_dn_wraps", 1, 32'(wcnt[1]), 32'd1);

    // Saturation at both ends.
    run(2, 1'b1, 1'b1, 12);
    chk("t3_up_q",     2, get_q(2),    32'd9);
    chk("t3_up_wraps", 2, 32'(wcnt[2]), 32'd3);
    wcnt[2] = 0;
    run(2, 1'b1, 1'b0, 12);
    chk("t3_dn_q",     2, get_q(2),    32'd0);
    chk("t3_dn_min",   2, 32'(mn[2]),   32'd1);
    chk("t3_dn_wraps", 2, 32'(wcnt[2]), 32'd3);

    // Prescaler by 3, including a freeze mid-count.
    run(3, 1'b1, 1'b1, 9);
    chk("t4_q",     3, get_q(3),    32'd3);
    chk("t4_steps", 3, 32'(scnt[3]), 32'd3);
    run(3, 1'b0, 1'b1, 5);
    chk("t4_hold_q", 3, get_q(3), 32'd3);
    run(3, 1'b1, 1'b1, 1);
    run(3, 1'b0, 1'b1, 3);
    run(3, 1'b1, 1'b1, 2);
    chk("t4_frozen_pre_q", 3, get_q(3), 32'd4);

    // Load with clamp, overriding an enabled step.
    en[3] = 1'b1; up[3] = 1'b1; load[3] = 1'b1; dval[3] = 13;
    cyc();
    chk("t5_clamp_q",    3, get_q(3),  32'd9);
    chk("t5_clamp_wrap", 3, 32'(wr[3]), 32'd0);
    dval[3] = 4;
    cyc();
    load[3] = 1'b0;
    en[3] = 1'b0;
    chk("t5_load_q", 3, get_q(3), 32'd4);

    // Async reset with q=7, pre=2, then resume.
    run(3, 1'b1, 1'b1, 11);
    chk("t6_pre_q", 3, get_q(3), 32'd7);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("t6_async");
    @(posedge test_clk);
    #1;
    rst = 1'b0;
    run(3, 1'b1, 1'b1, 3);
    chk("t6_resume_q", 3, get_q(3), 32'd1);

    // Randomized traffic on all four instances.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++) begin
        en[i]   = ($urandom % 4) != 0;
        up[i]   = ($urandom % 3) != 0;
        load[i] = ($urandom % 16) == 0;
        dval[i] = int'($urandom_range(0, (i == 0) ? 1023 : 15));
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
